// File: rtl/lector_operandos.sv
// Serial decoder for the captured 7-segment expression: one digit slot per clock,
// then a commit cycle that applies sign and operator and flags illegal codes.
module lector_operandos #(
   parameter logic [6:0] SEG_BLANK = 7'b1111111,
   parameter logic [6:0] SEG_MINUS = 7'b0111111,
   parameter logic [6:0] OP_ADD    = 7'b0001111,
   parameter logic [6:0] OP_SUB    = 7'b0111110,
   parameter logic [6:0] OP_MUL    = 7'b0001001,
   parameter logic [6:0] OP_DIV    = 7'b0101111
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [6:0]         signo1,
   input  logic [20:0]        Ssegnum1,
   input  logic [6:0]         operador,
   input  logic [20:0]        Ssegnum2,
   output logic signed [10:0] num1,
   output logic [9:0]         num2,
   output logic [1:0]         op,
   output logic               busy,
   output logic               done,
   output logic               error
);

   typedef enum logic [1:0] {IDLE, DIG, FIN} state_t;

   state_t             state, state_nx;
   logic [2:0]         idx, idx_nx;
   logic [9:0]         acc, acc_nx;
   logic [9:0]         mag1, mag1_nx;
   logic               err, err_nx;
   logic [6:0]         sign_q, sign_nx;
   logic [6:0]         oper_q, oper_nx;
   logic [41:0]        slots, slots_nx;
   logic signed [10:0] num1_nx;
   logic [9:0]         num2_nx;
   logic [1:0]         op_nx;
   logic               busy_nx, done_nx, error_nx;

   logic [6:0]         slot;
   logic [4:0]         dec;
   logic [9:0]         acc_step;
   logic [2:0]         opd;
   logic               sign_ok;

   // {legal, value}
   function automatic logic [4:0] seg_digit(input logic [6:0] code);
      case (code)
         7'b1000000: return {1'b1, 4'd0};
         7'b1111001: return {1'b1, 4'd1};
         7'b0100100: return {1'b1, 4'd2};
         7'b0110000: return {1'b1, 4'd3};
         7'b0011001: return {1'b1, 4'd4};
         7'b0010010: return {1'b1, 4'd5};
         7'b0000010: return {1'b1, 4'd6};
         7'b1111000: return {1'b1, 4'd7};
         7'b0000000: return {1'b1, 4'd8};
         7'b0010000: return {1'b1, 4'd9};
         default:    return 5'b0;
      endcase
   endfunction

   // {legal, op}
   function automatic logic [2:0] op_code(input logic [6:0] code);
      if (code == OP_ADD) return 3'b100;
      if (code == OP_SUB) return 3'b101;
      if (code == OP_MUL) return 3'b110;
      if (code == OP_DIV) return 3'b111;
      return 3'b000;
   endfunction

   function automatic logic signed [10:0] apply_sign(input logic [9:0] mag, input logic neg);
      logic signed [10:0] ext;
      ext = signed'({1'b0, mag});
      return neg ? -ext : ext;
   endfunction

   assign slot     = slots[41:35];
   assign dec      = seg_digit(slot);
   assign acc_step = (slot == SEG_BLANK || !dec[4]) ? acc : acc * 10'd10 + {6'd0, dec[3:0]};
   assign opd      = op_code(oper_q);
   assign sign_ok  = (sign_q == SEG_MINUS) || (sign_q == SEG_BLANK);

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      acc_nx   = acc;
      mag1_nx  = mag1;
      err_nx   = err;
      sign_nx  = sign_q;
      oper_nx  = oper_q;
      slots_nx = slots;
      num1_nx  = num1;
      num2_nx  = num2;
      op_nx    = op;
      busy_nx  = busy;
      done_nx  = 1'b0;
      error_nx = error;
      case (state)
         IDLE: begin
            if (start) begin
               sign_nx  = signo1;
               oper_nx  = operador;
               slots_nx = {Ssegnum1, Ssegnum2};
               idx_nx   = 3'd0;
               acc_nx   = 10'd0;
               err_nx   = 1'b0;
               busy_nx  = 1'b1;
               state_nx = DIG;
            end
         end
         DIG: begin
            if (slot != SEG_BLANK && !dec[4]) err_nx = 1'b1;
            slots_nx = {slots[34:0], 7'd0};
            idx_nx   = idx + 3'd1;
            // operand-1 magnitude is complete once its units slot is folded in
            if (idx == 3'd2) begin
               mag1_nx = acc_step;
               acc_nx  = 10'd0;
            end else begin
               acc_nx  = acc_step;
            end
            if (idx == 3'd5) state_nx = FIN;
         end
         FIN: begin
            if (err || !sign_ok || !opd[2]) begin
               num1_nx  = '0;
               num2_nx  = '0;
               op_nx    = 2'b00;
               error_nx = 1'b1;
            end else begin
               num1_nx  = apply_sign(mag1, sign_q == SEG_MINUS);
               num2_nx  = acc;
               op_nx    = opd[1:0];
               error_nx = 1'b0;
            end
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         acc    <= '0;
         mag1   <= '0;
         err    <= 1'b0;
         sign_q <= '0;
         oper_q <= '0;
         slots  <= '0;
         num1   <= '0;
         num2   <= '0;
         op     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         error  <= 1'b0;
      end else begin
         state  <= state_nx;
         idx    <= idx_nx;
         acc    <= acc_nx;
         mag1   <= mag1_nx;
         err    <= err_nx;
         sign_q <= sign_nx;
         oper_q <= oper_nx;
         slots  <= slots_nx;
         num1   <= num1_nx;
         num2   <= num2_nx;
         op     <= op_nx;
         busy   <= busy_nx;
         done   <= done_nx;
         error  <= error_nx;
      end
   end

endmodule

// File: tb/tb_lector_operandos.sv
// Bench for lector_operandos: directed vector table, multi-cycle corner sequences,
// and randomized expressions checked against a decimal reference model.
module tb_lector_operandos;

   localparam logic [6:0] BL  = 7'b1111111;
   localparam logic [6:0] MI  = 7'b0111111;
   localparam logic [6:0] ADD = 7'b0001111;
   localparam logic [6:0] SUB = 7'b0111110;
   localparam logic [6:0] MUL = 7'b0001001;
   localparam logic [6:0] DIV = 7'b0101111;
   localparam logic [6:0] BAD = 7'b1010101;

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [6:0]  signo1, operador;
   logic [20:0] Ssegnum1, Ssegnum2;
   logic [10:0] num1;
   logic [9:0]  num2;
   logic [1:0]  op;
   logic        busy, done, error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lector_operandos dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signo1(signo1), .Ssegnum1(Ssegnum1),
      .operador(operador), .Ssegnum2(Ssegnum2), .num1(num1), .num2(num2), .op(op),
      .busy(busy), .done(done), .error(error)
   );

   typedef struct {
      logic [6:0]  sg;
      logic [20:0] a;
      logic [6:0]  o;
      logic [20:0] b;
      logic [10:0] e1;
      logic [9:0]  e2;
      logic [1:0]  eop;
      logic        eerr;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // 0-9 digits, 10 blank, anything else an illegal code
   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         10: return BL;
         default: return BAD;
      endcase
   endfunction

   function automatic logic [20:0] dig3(input int h, input int t, input int u);
      return {seg(h), seg(t), seg(u)};
   endfunction

   function automatic vec_t model(input logic [6:0] sg, input logic [20:0] a,
                                  input logic [6:0] o, input logic [20:0] b);
      vec_t r;
      int   v[2];
      bit   bad;
      bit   neg;
      int   d;
      logic [20:0] opnd;
      logic [6:0]  code;
      r.sg = sg; r.a = a; r.o = o; r.b = b;
      bad = 0; neg = 0;
      for (int k = 0; k < 2; k++) begin
         v[k] = 0;
         opnd = (k == 0) ? a : b;
         for (int s = 0; s < 3; s++) begin
            code = opnd[20 - 7*s -: 7];
            d = -1;
            for (int j = 0; j < 10; j++) if (seg(j) == code) d = j;
            if (d >= 0) v[k] = v[k] * 10 + d;
            else if (code != BL) bad = 1;
         end
      end
      if (sg == MI) neg = 1;
      else if (sg != BL) bad = 1;
      if      (o == ADD) r.eop = 2'd0;
      else if (o == SUB) r.eop = 2'd1;
      else if (o == MUL) r.eop = 2'd2;
      else if (o == DIV) r.eop = 2'd3;
      else begin r.eop = 2'd0; bad = 1; end
      if (bad) begin
         r.e1 = '0; r.e2 = '0; r.eop = 2'd0; r.eerr = 1'b1;
      end else begin
         r.e1 = 11'(neg ? -v[0] : v[0]);
         r.e2 = 10'(v[1]);
         r.eerr = 1'b0;
      end
      return r;
   endfunction

   task automatic drive(input vec_t v);
      signo1 = v.sg; Ssegnum1 = v.a; operador = v.o; Ssegnum2 = v.b;
   endtask

   task automatic scramble();
      signo1 = 7'($urandom); operador = 7'($urandom);
      Ssegnum1 = 21'($urandom); Ssegnum2 = 21'($urandom);
   endtask

   // One decode; inputs are scrambled right after the start edge to prove the snapshot.
   task automatic run(input vec_t v, input string tag);
      int n;
      bit seen, overlap;
      @(negedge clk);
      drive(v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble();
      n = 0; seen = 0; overlap = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (busy && done) overlap = 1;
         if (done) seen = 1;
         else begin
            if (busy) n++;
            @(negedge clk);
         end
      end
      chk({tag, " done_seen"}, seen, 1);
      chk({tag, " busy_cycles"}, n, 7);
      chk({tag, " busy_done_overlap"}, overlap, 0);
      chk({tag, " num1"}, num1, v.e1);
      chk({tag, " num2"}, num2, v.e2);
      chk({tag, " op"}, op, v.eop);
      chk({tag, " error"}, error, v.eerr);
      @(negedge clk);
      chk({tag, " done_one_cycle"}, done, 0);
   endtask

   function automatic logic [6:0] rnd_slot();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) return seg($urandom_range(0, 9));
      if (r < 9) return BL;
      return 7'($urandom);
   endfunction

   initial begin
      int dpos[$];
      vec_t rv;
      logic [6:0] rs, ro;
      vecs[0] = '{BL, dig3(1,2,3),    ADD, dig3(4,5,6),    11'd123,  10'd456, 2'd0, 1'b0};
      vecs[1] = '{MI, dig3(9,9,9),    MUL, dig3(0,0,7),    11'h419,  10'd7,   2'd2, 1'b0};
      vecs[2] = '{BL, dig3(4,10,10),  DIV, dig3(10,10,10), 11'd4,    10'd0,   2'd3, 1'b0};
      vecs[3] = '{BL, dig3(1,2,3),    ADD, dig3(4,11,6),   11'd0,    10'd0,   2'd0, 1'b1};
      vecs[4] = '{BL, dig3(1,2,3),    SUB, dig3(4,5,6),    11'd123,  10'd456, 2'd1, 1'b0};
      vecs[5] = '{MI, dig3(0,0,0),    ADD, dig3(0,1,2),    11'd0,    10'd12,  2'd0, 1'b0};
      vecs[6] = '{seg(8), dig3(1,2,3), ADD, dig3(4,5,6),   11'd0,    10'd0,   2'd0, 1'b1};
      vecs[7] = '{BL, dig3(1,2,3),    BL,  dig3(4,5,6),    11'd0,    10'd0,   2'd0, 1'b1};
      vecs[8] = '{MI, dig3(10,10,5),  SUB, dig3(9,9,9),    11'h7FB,  10'd999, 2'd1, 1'b0};
      vecs[9] = '{BL, dig3(9,10,9),   MUL, dig3(10,3,10),  11'd99,   10'd3,   2'd2, 1'b0};

      // reset with start asserted
      rst_n = 1'b0; start = 1'b1;
      drive(vecs[0]);
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("rst num1", num1, 0);
      chk("rst num2", num2, 0);
      chk("rst op", op, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst error", error, 0);
      start = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      chk("rst no_decode", busy, 0);

      for (int i = 0; i < 10; i++) run(vecs[i], $sformatf("vec%0d", i));

      // start re-asserted mid-decode must not be queued
      @(negedge clk);
      drive(vecs[0]); start = 1'b1;
      dpos.delete();
      for (int n = 1; n <= 18; n++) begin
         @(negedge clk);
         start = (n == 3);
         if (done) dpos.push_back(n);
      end
      chk("ignore done_count", dpos.size(), 1);
      if (dpos.size() > 0) chk("ignore done_pos", dpos[0], 8);
      chk("ignore num1", num1, 123);

      // start held high: back-to-back decodes every 8 clocks
      drive(vecs[4]); start = 1'b1;
      dpos.delete();
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 9) start = 1'b0;
         if (done) dpos.push_back(n);
      end
      chk("b2b done_count", dpos.size(), 2);
      if (dpos.size() == 2) chk("b2b period", dpos[1] - dpos[0], 8);
      if (dpos.size() > 0) chk("b2b first_pos", dpos[0], 8);
      chk("b2b op", op, 1);

      // reset in the middle of a decode
      drive(vecs[1]); start = 1'b1;
      dpos.delete();
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (n == 4) rst_n = 1'b0;
         if (n == 5) begin
            chk("midrst busy", busy, 0);
            chk("midrst num1", num1, 0);
            chk("midrst num2", num2, 0);
            chk("midrst op", op, 0);
            rst_n = 1'b1;
         end
         if (done) dpos.push_back(n);
      end
      chk("midrst no_done", dpos.size(), 0);

      // randomized expressions against the reference model
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: rs = BL;
            3, 4:    rs = MI;
            default: rs = 7'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0: ro = ADD;
            1: ro = SUB;
            2: ro = MUL;
            3: ro = DIV;
            4: ro = BL;
            default: ro = 7'($urandom);
         endcase
         rv = model(rs, {rnd_slot(), rnd_slot(), rnd_slot()}, ro,
                    {rnd_slot(), rnd_slot(), rnd_slot()});
         run(rv, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
